// File: rtl/neuron_cfg_pkg.sv
// Shared types for the neuron configuration loader.
// Header layout, packet type codes, FSM states and word width.
package neuron_cfg_pkg;

  localparam int WORD_W   = 32;
  localparam int LAYER_W  = 6;
  localparam int NEURON_W = 10;
  localparam int COUNT_W  = 14;
  localparam int CNT_W    = COUNT_W + 1;

  typedef enum logic [1:0] {
    TYPE_ILL0   = 2'b00,
    TYPE_WEIGHT = 2'b01,
    TYPE_BIAS   = 2'b10,
    TYPE_ILL3   = 2'b11
  } pkt_type_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WEIGHT,
    ST_BIAS,
    ST_DRAIN,
    ST_CSUM,
    ST_DONE
  } state_e;

  // Field order matches the header word, MSB first.
  typedef struct packed {
    pkt_type_e             typ;
    logic [LAYER_W-1:0]    layer;
    logic [NEURON_W-1:0]   neuron;
    logic [COUNT_W-1:0]    count;
  } hdr_t;

endpackage

// File: rtl/neuron_cfg_loader_if.sv
// Valid/ready configuration stream into the loader.
// The host/DMA side is master, the loader is slave.
interface neuron_cfg_loader_if #(
  parameter int W = 32
) ();

  logic [W-1:0] s_data;
  logic         s_valid;
  logic         s_ready;

  modport master (
    output s_data,
    output s_valid,
    input  s_ready
  );

  modport slave (
    input  s_data,
    input  s_valid,
    output s_ready
  );

endinterface

// File: rtl/neuron_cfg_hdr_decode.sv
// Header splitter and classifier for the config loader.
// Trailer counting follows NEURON_CFG_LOADER_CSUM_EN.
module neuron_cfg_hdr_decode
  import neuron_cfg_pkg::*;
#(
  parameter int MAX_WEIGHTS = 784
) (
  input  logic [WORD_W-1:0]   i_hdr,
  output logic [LAYER_W-1:0]  o_layer,
  output logic [NEURON_W-1:0] o_neuron,
  output logic [CNT_W-1:0]    o_count,
  output logic                o_err,
  output state_e              o_next
);

  hdr_t w_hdr;
  logic w_zero;
  logic w_wt;
  logic w_bs;

  assign w_hdr    = hdr_t'(i_hdr);
  assign o_layer  = w_hdr.layer;
  assign o_neuron = w_hdr.neuron;

  assign w_zero = (w_hdr.count == '0);
  assign w_wt   = (w_hdr.typ == TYPE_WEIGHT)
               && !w_zero
               && (w_hdr.count <= COUNT_W'(MAX_WEIGHTS));
  assign w_bs   = (w_hdr.typ == TYPE_BIAS)
               && (w_hdr.count == COUNT_W'(1));

  always_comb begin
    o_err   = 1'b0;
    o_next  = ST_IDLE;
    o_count = CNT_W'(w_hdr.count);
    unique case (1'b1)
      w_zero: o_err = 1'b1;
      w_wt:   o_next = ST_WEIGHT;
      w_bs:   o_next = ST_BIAS;
      default: begin
        o_err  = 1'b1;
        o_next = ST_DRAIN;
`ifdef NEURON_CFG_LOADER_CSUM_EN
        // Drained packets still carry their trailer.
        o_count = CNT_W'(w_hdr.count) + CNT_W'(1);
`endif
      end
    endcase
  end

endmodule

// File: rtl/neuron_cfg_loader.sv
// Config sequencer driving the shared weight/bias load bus.
// Optional trailer checksum: NEURON_CFG_LOADER_CSUM_EN.
module neuron_cfg_loader
  import neuron_cfg_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int MAX_WEIGHTS = 784
) (
  input  logic                    clk,
  input  logic                    rst,
  neuron_cfg_loader_if.slave      s_if,
  output logic                    weightValid,
  output logic                    biasValid,
  output logic [2*DATA_WIDTH-1:0] weightValue,
  output logic [2*DATA_WIDTH-1:0] biasValue,
  output logic [2*DATA_WIDTH-1:0] config_layer_num,
  output logic [2*DATA_WIDTH-1:0] config_neuron_num,
  output logic                    busy,
  output logic                    done,
  output logic                    err
);

  localparam int W = 2 * DATA_WIDTH;

`ifdef NEURON_CFG_LOADER_CSUM_EN
  localparam state_e C_AFTER = ST_CSUM;
`else
  localparam state_e C_AFTER = ST_DONE;
`endif

  state_e              r_state;
  logic                r_s_ready;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_wv;
  logic                r_bv;
  logic [W-1:0]        r_wval;
  logic [W-1:0]        r_bval;
  logic [W-1:0]        r_layer;
  logic [W-1:0]        r_neuron;
  logic                r_done;
  logic                r_err;
`ifdef NEURON_CFG_LOADER_CSUM_EN
  logic [W-1:0]        r_sum;
`endif

  logic                w_acc;
  logic [LAYER_W-1:0]  w_layer;
  logic [NEURON_W-1:0] w_neuron;
  logic [CNT_W-1:0]    w_count;
  logic                w_err;
  state_e              w_next;

  assign w_acc = s_if.s_valid & r_s_ready;

  neuron_cfg_hdr_decode #(
    .MAX_WEIGHTS (MAX_WEIGHTS)
  ) u_dec (
    .i_hdr    (s_if.s_data),
    .o_layer  (w_layer),
    .o_neuron (w_neuron),
    .o_count  (w_count),
    .o_err    (w_err),
    .o_next   (w_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_s_ready <= 1'b0;
      r_cnt     <= '0;
      r_wv      <= 1'b0;
      r_bv      <= 1'b0;
      r_wval    <= '0;
      r_bval    <= '0;
      r_layer   <= '0;
      r_neuron  <= '0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
`ifdef NEURON_CFG_LOADER_CSUM_EN
      r_sum     <= '0;
`endif
    end else begin
      r_wv      <= 1'b0;
      r_bv      <= 1'b0;
      r_err     <= 1'b0;
      r_s_ready <= 1'b1;
      r_done    <= (r_state == ST_DONE);
      unique case (r_state)
        ST_IDLE: begin
          if (w_acc) begin
            r_layer  <= W'(w_layer);
            r_neuron <= W'(w_neuron);
            r_cnt    <= w_count;
            r_err    <= w_err;
            r_state  <= w_next;
`ifdef NEURON_CFG_LOADER_CSUM_EN
            r_sum    <= '0;
`endif
          end
        end
        ST_WEIGHT: begin
          if (w_acc) begin
            r_wval <= s_if.s_data;
            r_wv   <= 1'b1;
            r_cnt  <= r_cnt - CNT_W'(1);
`ifdef NEURON_CFG_LOADER_CSUM_EN
            r_sum  <= r_sum + s_if.s_data;
`endif
            if (r_cnt == CNT_W'(1)) begin
              r_state   <= C_AFTER;
              r_s_ready <= (C_AFTER != ST_DONE);
            end
          end
        end
        ST_BIAS: begin
          if (w_acc) begin
            r_bval    <= s_if.s_data;
            r_bv      <= 1'b1;
            r_cnt     <= '0;
`ifdef NEURON_CFG_LOADER_CSUM_EN
            r_sum     <= r_sum + s_if.s_data;
`endif
            r_state   <= C_AFTER;
            r_s_ready <= (C_AFTER != ST_DONE);
          end
        end
        ST_DRAIN: begin
          if (w_acc) begin
            r_cnt <= r_cnt - CNT_W'(1);
            if (r_cnt == CNT_W'(1)) begin
              r_state <= ST_IDLE;
            end
          end
        end
`ifdef NEURON_CFG_LOADER_CSUM_EN
        ST_CSUM: begin
          if (w_acc) begin
            if (s_if.s_data == r_sum) begin
              r_state   <= ST_DONE;
              r_s_ready <= 1'b0;
            end else begin
              r_err   <= 1'b1;
              r_state <= ST_IDLE;
            end
          end
        end
`endif
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign s_if.s_ready      = r_s_ready;
  assign weightValid       = r_wv;
  assign biasValid         = r_bv;
  assign weightValue       = r_wval;
  assign biasValue         = r_bval;
  assign config_layer_num  = r_layer;
  assign config_neuron_num = r_neuron;
  assign busy              = (r_state != ST_IDLE);
  assign done              = r_done;
  assign err               = r_err;

endmodule

// File: tb/tb_neuron_cfg_loader.sv
// Directed bench for neuron_cfg_loader with an event scoreboard.
// Define NEURON_CFG_LOADER_CSUM_EN to exercise trailer checks.
module tb_neuron_cfg_loader;

  localparam int EV_NONE = -1;
  localparam int EV_W    = 0;
  localparam int EV_B    = 1;
  localparam int EV_D    = 2;
  localparam int EV_E    = 3;

  typedef struct {
    int          kind;
    int          cyc;
    logic [31:0] val;
    logic [31:0] lay;
    logic [31:0] neu;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        weightValid;
  logic        biasValid;
  logic [31:0] weightValue;
  logic [31:0] biasValue;
  logic [31:0] config_layer_num;
  logic [31:0] config_neuron_num;
  logic        busy;
  logic        done;
  logic        err;

  int          cyc = 0;
  int          n_checks = 0;
  int          n_errors = 0;
  int          prev_end = -100;
  ev_t         q[$];
  logic [31:0] pl[$];
  logic [31:0] exp_lay = '0;
  logic [31:0] exp_neu = '0;

  neuron_cfg_loader_if #(.W(32)) bus ();

  neuron_cfg_loader #(
    .DATA_WIDTH  (16),
    .MAX_WEIGHTS (784)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .s_if              (bus),
    .weightValid       (weightValid),
    .biasValid         (biasValid),
    .weightValue       (weightValue),
    .biasValue         (biasValue),
    .config_layer_num  (config_layer_num),
    .config_neuron_num (config_neuron_num),
    .busy              (busy),
    .done              (done),
    .err               (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic see(input int kind, input logic [31:0] val);
    ev_t e;
    n_checks++;
    assert (q.size() > 0) else begin
      n_errors++;
      $error("FAIL unexpected_event: got kind %0d at cycle %0d want none",
             kind, cyc);
    end
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("ev_kind", kind, e.kind);
      chk("ev_cycle", cyc, e.cyc);
      chk("ev_value", val, e.val);
      if (kind == EV_W || kind == EV_B) begin
        chk("ev_layer", config_layer_num, e.lay);
        chk("ev_neuron", config_neuron_num, e.neu);
      end
    end
  endtask

  // Strobes/pulses are sampled on the falling edge.
  always @(negedge clk) begin
    if (weightValid) see(EV_W, weightValue);
    if (biasValid) see(EV_B, biasValue);
    if (done) see(EV_D, 32'h0);
    if (err) see(EV_E, 32'h0);
    if (done | err) chk("done_err_excl", done & err, 0);
  end

  task automatic push_ev(input int kind, input int c, input logic [31:0] v);
    ev_t e;
    e.kind = kind;
    e.cyc  = c;
    e.val  = v;
    e.lay  = exp_lay;
    e.neu  = exp_neu;
    q.push_back(e);
  endtask

  task automatic send_word(input logic [31:0] w, input int kind,
                           output int acc);
    bit seen;
    seen = 1'b0;
    acc  = -1;
    bus.s_valid = 1'b1;
    bus.s_data  = w;
    for (int i = 0; i < 64 && !seen; i++) begin
      if (bus.s_ready) begin
        seen = 1'b1;
        acc  = cyc + 1;
        if (kind == EV_W || kind == EV_B) push_ev(kind, acc, w);
        else if (kind != EV_NONE) push_ev(kind, acc, 32'h0);
      end
      @(negedge clk);
    end
    chk("accept_timeout", seen, 1);
  endtask

  task automatic send_pkt(input logic [1:0] typ, input logic [5:0] lay,
                          input logic [9:0] neu, input int gap,
                          input bit bad);
    int          n;
    int          acc;
    int          wk;
    bit          legal;
    logic [31:0] sum;
    n     = pl.size();
    sum   = '0;
    legal = (n != 0) && ((typ == 2'b01 && n <= 784) ||
                         (typ == 2'b10 && n == 1));
    exp_lay = {26'b0, lay};
    exp_neu = {22'b0, neu};
    send_word({typ, lay, neu, 14'(n)}, legal ? EV_NONE : EV_E, acc);
    if (prev_end >= 0) chk("turnaround", (acc - prev_end) >= 2, 1);
    prev_end = -100;
    wk = !legal ? EV_NONE : ((typ == 2'b01) ? EV_W : EV_B);
    for (int i = 0; i < n; i++) begin
      send_word(pl[i], wk, acc);
      sum = sum + pl[i];
      if (gap > 0 && i < n - 1) begin
        bus.s_valid = 1'b0;
        repeat (gap) @(negedge clk);
      end
    end
`ifdef NEURON_CFG_LOADER_CSUM_EN
    if (n != 0) begin
      send_word(sum + (bad ? 32'd1 : 32'd0),
                (legal && bad) ? EV_E : EV_NONE, acc);
    end
    if (legal && !bad) begin
      push_ev(EV_D, acc + 1, 32'h0);
      prev_end = acc;
    end
`else
    if (legal) begin
      push_ev(EV_D, acc + 1, 32'h0);
      prev_end = acc;
    end
`endif
    bus.s_valid = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_s_ready"}, bus.s_ready, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_wv"}, weightValid, 0);
    chk({tag, "_bv"}, biasValid, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_wval"}, weightValue, 0);
    chk({tag, "_bval"}, biasValue, 0);
    chk({tag, "_layer"}, config_layer_num, 0);
    chk({tag, "_neuron"}, config_neuron_num, 0);
  endtask

  initial begin
    int acc;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", bus.s_ready, 1);
    chk("idle_after_reset", busy, 0);

    pl = {32'd5, 32'd6, 32'd7, 32'd8};
    send_pkt(2'b01, 6'd1, 10'd3, 0, 1'b0);

    pl = {32'h0000_0100};
    send_pkt(2'b10, 6'd2, 10'd0, 0, 1'b0);

    pl = {32'd9, 32'd10, 32'd11};
    send_pkt(2'b11, 6'd4, 10'd5, 0, 1'b0);

    pl = {32'hDEAD_0001, 32'hBEEF_0002};
    send_pkt(2'b01, 6'd63, 10'd1023, 0, 1'b0);

    pl = {32'h11, 32'h22, 32'h33};
    send_pkt(2'b01, 6'd3, 10'd1, 2, 1'b0);

    pl.delete();
    send_pkt(2'b01, 6'd7, 10'd2, 0, 1'b0);
    chk("latch_on_zero_layer", config_layer_num, 7);
    chk("zero_count_idle", busy, 0);

    pl = {32'd1, 32'd2};
    send_pkt(2'b00, 6'd8, 10'd8, 0, 1'b0);

    pl = {32'd3, 32'd4};
    send_pkt(2'b10, 6'd9, 10'd9, 0, 1'b0);

    // Abort a weight packet after two of four words.
    exp_lay = 32'd5;
    exp_neu = 32'd9;
    send_word({2'b01, 6'd5, 10'd9, 14'd4}, EV_NONE, acc);
    chk("busy_in_pkt", busy, 1);
    send_word(32'hA1, EV_W, acc);
    send_word(32'hA2, EV_W, acc);
    rst = 1'b1;
    bus.s_data = 32'hA3;
    @(negedge clk);
    chk_all_zero("midreset");
    bus.s_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_abort", bus.s_ready, 1);
    prev_end = -100;

    pl = {32'hC1, 32'hC2, 32'hC3, 32'hC4};
    send_pkt(2'b01, 6'd5, 10'd9, 0, 1'b0);

    pl.delete();
    for (int i = 0; i < 784; i++) pl.push_back(32'(i * 3 + 1));
    send_pkt(2'b01, 6'd10, 10'd100, 0, 1'b0);

    pl.push_back(32'h5555);
    send_pkt(2'b01, 6'd11, 10'd101, 0, 1'b0);

`ifdef NEURON_CFG_LOADER_CSUM_EN
    pl = {32'd1, 32'd2, 32'd3};
    send_pkt(2'b01, 6'd12, 10'd4, 0, 1'b0);
    pl = {32'd1, 32'd2, 32'd3};
    send_pkt(2'b01, 6'd12, 10'd5, 0, 1'b1);
    pl = {32'h0000_0100};
    send_pkt(2'b10, 6'd13, 10'd6, 0, 1'b1);
`endif

    pl = {32'hF0};
    send_pkt(2'b10, 6'd14, 10'd7, 0, 1'b0);

    repeat (4) @(negedge clk);
    chk("scoreboard_empty", q.size(), 0);
    chk("final_idle", busy, 0);
    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
